// File: rtl/game_frame_scanner_pkg.sv
// Shared display constants: byte-wide coordinates, 3-bit colour, default screen size.
package game_frame_scanner_pkg;

  localparam int UBYTE_W      = 8;
  localparam int COLOR_W      = 3;
  localparam int WAIT_W       = 4;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  typedef logic [UBYTE_W-1:0] ubyte_t;
  typedef logic [COLOR_W-1:0] color_t;

endpackage

// File: rtl/rising_edge_detect.sv
// One-cycle pulse on a rising edge of a clk-synchronous level; reset clears the history
// so a level already high at release is seen as an edge.
module rising_edge_detect (
  input  logic clk,
  input  logic resetn,
  input  logic in,
  output logic pulse
);

  logic r_in_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_in_q <= 1'b0;
    end else begin
      r_in_q <= in;
    end
  end

  assign pulse = in & ~r_in_q;

endmodule

// File: rtl/game_frame_scanner.sv
// Sweeps every screen pixel once per frame request: strobe the renderer, wait for its
// colour, then write the pixel to the VGA adapter with a one-cycle plot pulse.
module game_frame_scanner
  import game_frame_scanner_pkg::*;
#(
  parameter int SCREEN_W   = DEF_SCREEN_W,
  parameter int SCREEN_H   = DEF_SCREEN_H,
  parameter int RENDER_LAT = 2
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   frameClk,
  input  color_t renderColor,
  output ubyte_t x,
  output ubyte_t y,
  output logic   ldClk,
  output ubyte_t vgaX,
  output ubyte_t vgaY,
  output color_t vgaColor,
  output logic   plot,
  output logic   busy,
  output logic   frameDone,
  output logic   frameOverrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_SET, S_LOAD, S_WAIT, S_PLOT, S_ADVANCE, S_DONE
  } state_t;

  localparam ubyte_t             LAST_X    = UBYTE_W'(SCREEN_W - 1);
  localparam ubyte_t             LAST_Y    = UBYTE_W'(SCREEN_H - 1);
  localparam logic [WAIT_W-1:0]  LAST_WAIT = WAIT_W'(RENDER_LAT - 1);

  state_t             r_state;
  state_t             w_state_next;
  ubyte_t             r_x;
  ubyte_t             r_y;
  ubyte_t             r_vga_x;
  ubyte_t             r_vga_y;
  color_t             r_vga_color;
  logic [WAIT_W-1:0]  r_wait;
  logic               r_overrun;
  logic               w_start;
  logic               w_last_wait;
  logic               w_last_pixel;

  rising_edge_detect u_start_detect (
    .clk    (clk),
    .resetn (resetn),
    .in     (frameClk),
    .pulse  (w_start)
  );

  assign w_last_wait  = (r_wait == LAST_WAIT);
  assign w_last_pixel = (r_x == LAST_X) && (r_y == LAST_Y);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_start) w_state_next = S_SET;
      S_SET:     w_state_next = S_LOAD;
      S_LOAD:    w_state_next = S_WAIT;
      S_WAIT:    if (w_last_wait) w_state_next = S_PLOT;
      S_PLOT:    w_state_next = S_ADVANCE;
      S_ADVANCE: w_state_next = w_last_pixel ? S_DONE : S_SET;
      S_DONE:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_vga_x     <= '0;
      r_vga_y     <= '0;
      r_vga_color <= '0;
      r_wait      <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      // A request seen in any non-idle state (DONE included) is dropped and flagged.
      r_overrun <= w_start && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_x <= '0;
            r_y <= '0;
          end
        end
        S_LOAD: r_wait <= '0;
        S_WAIT: begin
          r_wait <= r_wait + 1'b1;
          if (w_last_wait) begin
            r_vga_x     <= r_x;
            r_vga_y     <= r_y;
            r_vga_color <= renderColor;
          end
        end
        S_ADVANCE: begin
          // The final pixel returns straight to the origin rather than stepping y past the screen.
          if (w_last_pixel) begin
            r_x <= '0;
            r_y <= '0;
          end else if (r_x == LAST_X) begin
            r_x <= '0;
            r_y <= r_y + 1'b1;
          end else begin
            r_x <= r_x + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign x            = r_x;
  assign y            = r_y;
  assign vgaX         = r_vga_x;
  assign vgaY         = r_vga_y;
  assign vgaColor     = r_vga_color;
  assign ldClk        = (r_state == S_LOAD);
  assign plot         = (r_state == S_PLOT);
  assign frameDone    = (r_state == S_DONE);
  assign busy         = (r_state != S_IDLE) && (r_state != S_DONE);
  assign frameOverrun = r_overrun;

endmodule

// File: tb/tb_game_frame_scanner.sv
// Directed bench for game_frame_scanner on a 4x2 screen with a two-cycle renderer model.
module tb_game_frame_scanner;

  localparam int SW  = 4;
  localparam int SH  = 2;
  localparam int LAT = 2;
  localparam int PIX = SW * SH;
  localparam int PER = 4 + LAT;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       frameClk = 1'b0;
  logic [2:0] renderColor;
  logic [7:0] x, y, vgaX, vgaY;
  logic [2:0] vgaColor;
  logic       ldClk, plot, busy, frameDone, frameOverrun;

  int compared = 0;
  int mismatched = 0;

  game_frame_scanner #(.SCREEN_W(SW), .SCREEN_H(SH), .RENDER_LAT(LAT)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .frameClk     (frameClk),
    .renderColor  (renderColor),
    .x            (x),
    .y            (y),
    .ldClk        (ldClk),
    .vgaX         (vgaX),
    .vgaY         (vgaY),
    .vgaColor     (vgaColor),
    .plot         (plot),
    .busy         (busy),
    .frameDone    (frameDone),
    .frameOverrun (frameOverrun)
  );

  always #5 clk = ~clk;

  // Renderer model: correct colour only in the window around the capturing edge,
  // LAT cycles after the load strobe; the inverted colour at all other times.
  logic [LAT:0] ld_pipe = '0;
  logic [2:0]   ld_color = '0;
  always @(negedge clk) begin
    ld_pipe <= {ld_pipe[LAT-1:0], ldClk};
    if (ldClk) ld_color <= x[2:0] ^ y[2:0];
  end
  assign renderColor = ld_pipe[LAT] ? ld_color : ~ld_color;

  typedef struct {
    int         cyc;
    logic [7:0] px;
    logic [7:0] py;
    logic [2:0] pc;
  } plot_t;

  int    cyc = 0;
  plot_t plot_q[$];
  int    done_cnt = 0;
  int    done_cyc = 0;
  logic  done_busy = 1'b0;
  int    ovr_cnt = 0;
  int    bad_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    plot_t rec;
    if (plot) begin
      rec.cyc = cyc;
      rec.px  = vgaX;
      rec.py  = vgaY;
      rec.pc  = vgaColor;
      plot_q.push_back(rec);
    end
    if (frameDone) begin
      done_cnt  = done_cnt + 1;
      done_cyc  = cyc;
      done_busy = busy;
    end
    if (frameOverrun) ovr_cnt = ovr_cnt + 1;
    if ((plot && ldClk) || (plot && !busy)) bad_cnt = bad_cnt + 1;
  end

  task automatic test_reset();
    logic [40:0] outs;
    resetn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      frameClk = ~frameClk;
      #1;
      outs = {x, y, vgaX, vgaY, vgaColor, ldClk, plot, busy, frameDone, frameOverrun};
      compared++;
      if (outs !== '0) begin
        mismatched++;
        $display("FAIL reset_outputs cycle %0d: got %h, want 0", i, outs);
      end
    end
    @(negedge clk);
    frameClk = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    compared++;
    if (busy !== 1'b0 || plot_q.size() != 0) begin
      mismatched++;
      $display("FAIL reset_idle: busy=%b plots=%0d, want busy=0 plots=0", busy, plot_q.size());
    end
    $display("test_reset: done");
  endtask

  task automatic test_frame();
    int pb, db, s, n;
    logic [7:0] ex, ey;
    logic [2:0] ec;
    pb = plot_q.size();
    db = done_cnt;
    @(negedge clk);
    frameClk = 1'b1;
    s = cyc;
    @(negedge clk);
    frameClk = 1'b0;
    for (int i = 0; i < 300 && done_cnt == db; i++) @(negedge clk);
    compared++;
    if (done_cnt == db) begin
      mismatched++;
      $display("FAIL frame_timeout: frameDone count %0d, want %0d", done_cnt, db + 1);
    end
    n = plot_q.size() - pb;
    compared++;
    if (n != PIX) begin
      mismatched++;
      $display("FAIL frame_plot_count: got %0d, want %0d", n, PIX);
    end
    if (n > PIX) n = PIX;
    for (int i = 0; i < n; i++) begin
      ex = 8'(i % SW);
      ey = 8'(i / SW);
      ec = ex[2:0] ^ ey[2:0];
      compared++;
      if (plot_q[pb+i].px !== ex || plot_q[pb+i].py !== ey || plot_q[pb+i].pc !== ec) begin
        mismatched++;
        $display("FAIL frame_pixel %0d: got (%0d,%0d) c=%0d, want (%0d,%0d) c=%0d", i,
                 plot_q[pb+i].px, plot_q[pb+i].py, plot_q[pb+i].pc, ex, ey, ec);
      end
      compared++;
      if (plot_q[pb+i].cyc - s != 3 + LAT + PER * i) begin
        mismatched++;
        $display("FAIL frame_plot_time %0d: got %0d cycles after start, want %0d", i,
                 plot_q[pb+i].cyc - s, 3 + LAT + PER * i);
      end
      $display("plot %0d: (%0d,%0d) color %0d at +%0d", i, plot_q[pb+i].px, plot_q[pb+i].py,
               plot_q[pb+i].pc, plot_q[pb+i].cyc - s);
    end
    compared++;
    if (done_cyc - s != 3 + LAT + PER * (PIX - 1) + 2 || done_busy !== 1'b0) begin
      mismatched++;
      $display("FAIL frame_done_time: got +%0d busy=%b, want +%0d busy=0", done_cyc - s, done_busy,
               3 + LAT + PER * (PIX - 1) + 2);
    end
    compared++;
    if (bad_cnt != 0) begin
      mismatched++;
      $display("FAIL plot_conflict: got %0d bad plot cycles, want 0", bad_cnt);
    end
    $display("test_frame: done");
  endtask

  task automatic test_overrun();
    int pb, db, ob;
    pb = plot_q.size();
    db = done_cnt;
    ob = ovr_cnt;
    @(negedge clk);
    frameClk = 1'b1;
    @(negedge clk);
    frameClk = 1'b0;
    for (int i = 0; i < 200 && plot_q.size() < pb + 3; i++) @(negedge clk);
    frameClk = 1'b1;
    @(negedge clk);
    frameClk = 1'b0;
    for (int i = 0; i < 300 && done_cnt == db; i++) @(negedge clk);
    repeat (40) @(negedge clk);
    compared++;
    if (ovr_cnt - ob != 1) begin
      mismatched++;
      $display("FAIL overrun_count: got %0d, want 1", ovr_cnt - ob);
    end
    compared++;
    if (plot_q.size() - pb != PIX || done_cnt - db != 1) begin
      mismatched++;
      $display("FAIL overrun_frames: got %0d plots %0d dones, want %0d plots 1 done",
               plot_q.size() - pb, done_cnt - db, PIX);
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL overrun_idle: busy got %b, want 0", busy);
    end
    $display("test_overrun: overruns=%0d plots=%0d", ovr_cnt - ob, plot_q.size() - pb);
  endtask

  task automatic test_reset_mid();
    int pb, db;
    pb = plot_q.size();
    @(negedge clk);
    frameClk = 1'b1;
    @(negedge clk);
    frameClk = 1'b0;
    for (int i = 0; i < 200 && plot_q.size() < pb + 5; i++) @(negedge clk);
    for (int i = 0; i < 20 && !ldClk; i++) @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    compared++;
    if ({plot, ldClk, busy} !== 3'b000 || x !== 8'd0 || y !== 8'd0) begin
      mismatched++;
      $display("FAIL reset_mid_async: plot/ld/busy=%b x=%0d y=%0d, want 000 0 0",
               {plot, ldClk, busy}, x, y);
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (30) @(negedge clk);
    compared++;
    if (plot_q.size() - pb != 5) begin
      mismatched++;
      $display("FAIL reset_mid_noplot: got %0d plots, want 5", plot_q.size() - pb);
    end
    pb = plot_q.size();
    db = done_cnt;
    frameClk = 1'b1;
    @(negedge clk);
    frameClk = 1'b0;
    for (int i = 0; i < 300 && done_cnt == db; i++) @(negedge clk);
    compared++;
    if (plot_q.size() - pb != PIX) begin
      mismatched++;
      $display("FAIL reset_mid_restart_count: got %0d plots, want %0d", plot_q.size() - pb, PIX);
    end else begin
      compared++;
      if (plot_q[pb].px !== 8'd0 || plot_q[pb].py !== 8'd0) begin
        mismatched++;
        $display("FAIL reset_mid_restart_origin: got (%0d,%0d), want (0,0)",
                 plot_q[pb].px, plot_q[pb].py);
      end
    end
    $display("test_reset_mid: restart plots=%0d", plot_q.size() - pb);
  endtask

  task automatic test_level_held();
    int pb, db, ob;
    pb = plot_q.size();
    db = done_cnt;
    ob = ovr_cnt;
    @(negedge clk);
    frameClk = 1'b1;
    repeat (100) @(negedge clk);
    frameClk = 1'b0;
    repeat (20) @(negedge clk);
    compared++;
    if (plot_q.size() - pb != PIX || done_cnt - db != 1) begin
      mismatched++;
      $display("FAIL level_held: got %0d plots %0d dones, want %0d plots 1 done",
               plot_q.size() - pb, done_cnt - db, PIX);
    end
    compared++;
    if (ovr_cnt - ob != 0 || bad_cnt != 0) begin
      mismatched++;
      $display("FAIL level_held_flags: got overruns=%0d bad=%0d, want 0 0", ovr_cnt - ob, bad_cnt);
    end
    $display("test_level_held: plots=%0d dones=%0d", plot_q.size() - pb, done_cnt - db);
  endtask

  initial begin
    test_reset();
    test_frame();
    test_overrun();
    test_reset_mid();
    test_level_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
